// File: rtl/stream_pkg.sv
// Shared definitions for the stream register-slice pipeline.
// Slice-mode selectors and occupancy-width helper.
package stream_pkg;

  localparam bit SLICE_PIPE  = 1'b0;
  localparam bit SLICE_SPILL = 1'b1;

  function automatic int cnt_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_pipeline_slice.sv
// One valid/ready register slice: pipe (1 entry, combinational ready)
// or spill (2 entries, registered ready).
module stream_pipeline_slice
  import stream_pkg::*;
#(
  parameter type T         = logic,
  parameter bit  CUT_READY = SLICE_PIPE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       testmode_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  T           data_i,
  output logic       valid_o,
  input  logic       ready_i,
  output T           data_o,
  output logic [1:0] occ_o
);

  logic unused_testmode;
  assign unused_testmode = testmode_i;

  logic push;
  logic pop;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  if (CUT_READY == SLICE_SPILL) begin : g_spill
    logic a_vld_q, a_vld_d;
    logic b_vld_q, b_vld_d;
    T     a_dat_q, a_dat_d;
    T     b_dat_q, b_dat_d;

    always_comb begin
      a_vld_d = a_vld_q;
      b_vld_d = b_vld_q;
      a_dat_d = a_dat_q;
      b_dat_d = b_dat_q;
      if (clr_i) begin
        a_vld_d = 1'b0;
        b_vld_d = 1'b0;
      end else begin
        if (pop) begin
          if (b_vld_q) begin
            a_dat_d = b_dat_q;
            b_vld_d = 1'b0;
          end else begin
            a_vld_d = 1'b0;
          end
        end
        // push implies B empty, so a popping A frees it for this beat
        if (push) begin
          if (!a_vld_q || pop) begin
            a_vld_d = 1'b1;
            a_dat_d = data_i;
          end else begin
            b_vld_d = 1'b1;
            b_dat_d = data_i;
          end
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_vld_q <= 1'b0;
        b_vld_q <= 1'b0;
        a_dat_q <= '0;
        b_dat_q <= '0;
      end else begin
        a_vld_q <= a_vld_d;
        b_vld_q <= b_vld_d;
        a_dat_q <= a_dat_d;
        b_dat_q <= b_dat_d;
      end
    end

    assign ready_o = ~clr_i & ~b_vld_q;
    assign valid_o = ~clr_i & a_vld_q;
    assign data_o  = a_dat_q;
    assign occ_o   = 2'(a_vld_d) + 2'(b_vld_d);
  end else begin : g_pipe
    logic vld_q, vld_d;
    T     dat_q, dat_d;

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (clr_i) begin
        vld_d = 1'b0;
      end else if (push) begin
        vld_d = 1'b1;
        dat_d = data_i;
      end else if (pop) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign ready_o = ~clr_i & (~vld_q | ready_i);
    assign valid_o = ~clr_i & vld_q;
    assign data_o  = dat_q;
    assign occ_o   = {1'b0, vld_d};
  end

endmodule

// File: rtl/stream_pipeline.sv
// Chain of NUM_STAGES valid/ready slices with a registered
// occupancy count; NUM_STAGES=0 is a plain wire-through.
module stream_pipeline
  import stream_pkg::*;
#(
  parameter type T          = logic,
  parameter int  NUM_STAGES = 2,
  parameter bit  CUT_READY  = SLICE_PIPE,
  parameter int  CNT_W      =
    cnt_width(NUM_STAGES * (CUT_READY ? 2 : 1))
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             testmode_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  T                 data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output T                 data_o,
  output logic [CNT_W-1:0] count_o
);

  if (NUM_STAGES < 0) begin : g_bad_param
    $error("stream_pipeline: NUM_STAGES must be >= 0");
  end

  if (NUM_STAGES <= 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk_i ^ rst_ni ^ testmode_i;
    assign valid_o = valid_i & ~clr_i;
    assign ready_o = ready_i & ~clr_i;
    assign data_o  = data_i;
    assign count_o = '0;
  end else begin : g_chain
    logic             vld_s [NUM_STAGES+1];
    logic             rdy_s [NUM_STAGES+1];
    T                 dat_s [NUM_STAGES+1];
    logic [1:0]       occ_s [NUM_STAGES];
    logic [CNT_W-1:0] count_q, count_d;
    int               occ_sum;

    assign vld_s[0]          = valid_i;
    assign dat_s[0]          = data_i;
    assign ready_o           = rdy_s[0];
    assign valid_o           = vld_s[NUM_STAGES];
    assign data_o            = dat_s[NUM_STAGES];
    assign rdy_s[NUM_STAGES] = ready_i;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slice
      stream_pipeline_slice #(
        .T         (T),
        .CUT_READY (CUT_READY)
      ) u_slice (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .testmode_i (testmode_i),
        .valid_i    (vld_s[i]),
        .ready_o    (rdy_s[i]),
        .data_i     (dat_s[i]),
        .valid_o    (vld_s[i+1]),
        .ready_i    (rdy_s[i+1]),
        .data_o     (dat_s[i+1]),
        .occ_o      (occ_s[i])
      );
    end

    // slices report next-state occupancy, so the count tracks the edge
    always_comb begin
      occ_sum = 0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        occ_sum = occ_sum + int'(occ_s[i]);
      end
      count_d = CNT_W'(occ_sum);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign count_o = count_q;
  end

endmodule

// File: tb/tb_stream_pipeline.sv
// Self-checking bench: several pipeline configs, directed cases
// and a random queue-model scoreboard.
module tb_stream_pipeline;

  localparam int NI = 7;

  function automatic int ns_of(input int k);
    case (k)
      0, 1:    return 2;
      2:       return 0;
      3, 4:    return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit cr_of(input int k);
    return (k == 1) || (k == 4) || (k == 6);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic       vi   [NI];
  logic       ro   [NI];
  logic       vo   [NI];
  logic       ri   [NI];
  logic [7:0] di   [NI];
  logic [7:0] dout [NI];
  logic [3:0] co   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NS = ns_of(g);
    localparam bit CR = cr_of(g);
    localparam int CW =
      stream_pkg::cnt_width(NS * (CR ? 2 : 1));
    logic [CW-1:0] cnt;
    stream_pipeline #(
      .T          (logic [7:0]),
      .NUM_STAGES (NS),
      .CUT_READY  (CR)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (clr),
      .testmode_i (1'b0),
      .valid_i    (vi[g]),
      .ready_o    (ro[g]),
      .data_i     (di[g]),
      .valid_o    (vo[g]),
      .ready_i    (ri[g]),
      .data_o     (dout[g]),
      .count_o    (cnt)
    );
    assign co[g] = 4'(cnt);
  end

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mem    [NI][16];
  int         head   [NI];
  int         tail   [NI];
  int         sent   [NI];
  int         rcv    [NI];
  bit         fired  [NI];
  bit         stall  [NI];
  logic [7:0] hold_d [NI];
  logic [7:0] last   [NI];

  task automatic chk(input string tag, input int k,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h",
                  tag, k, got, exp);
  endtask

  // evaluate the cycle just before the edge, then advance
  task automatic step();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("count", k, co[k], tail[k] - head[k]);
      if (stall[k] && !clr) begin
        chk("hold_v", k, vo[k], 1);
        chk("hold_d", k, dout[k], hold_d[k]);
      end
      fired[k] = 1'b0;
      if (clr) begin
        chk("clr_rdy", k, ro[k], 0);
        chk("clr_vld", k, vo[k], 0);
        head[k] = tail[k];
        stall[k] = 1'b0;
      end else begin
        if (vi[k] && ro[k]) begin
          mem[k][tail[k] % 16] = di[k];
          tail[k]++;
          sent[k]++;
          fired[k] = 1'b1;
        end
        if (vo[k] && ri[k]) begin
          if (tail[k] == head[k]) begin
            chk("spurious", k, vo[k], 0);
          end else begin
            chk("data", k, dout[k], mem[k][head[k] % 16]);
            head[k]++;
          end
          rcv[k]++;
          last[k] = dout[k];
        end
        stall[k] = vo[k] && !ri[k];
        hold_d[k] = dout[k];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vi[k] = 1'b0;
      ri[k] = 1'b0;
      di[k] = '0;
      head[k] = tail[k];
      stall[k] = 1'b0;
      fired[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tx;
    int r0;
    int s0 [2];
    int q0 [2];
    int rb [NI];
    int cyc;
    bit busy;

    for (int k = 0; k < NI; k++) begin
      head[k] = 0; tail[k] = 0; sent[k] = 0; rcv[k] = 0;
    end
    do_reset();

    // reset state, then single beat through 2-stage pipe
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_vld", k, vo[k], 0);
      chk("rst_cnt", k, co[k], 0);
      chk("rst_dat", k, dout[k], 0);
      chk("rst_rdy", k, ro[k], (ns_of(k) == 0) ? ri[k] : 1'b1);
    end
    vi[0] = 1'b1; di[0] = 8'hA5; ri[0] = 1'b1;
    step();
    vi[0] = 1'b0;
    #1;
    chk("t1_cnt0", 0, co[0], 1);
    chk("t1_vld0", 0, vo[0], 0);
    step();
    #1;
    chk("t1_vld1", 0, vo[0], 1);
    chk("t1_dat1", 0, dout[0], 8'hA5);
    chk("t1_cnt1", 0, co[0], 1);
    step();
    #1;
    chk("t1_cnt2", 0, co[0], 0);
    chk("t1_vld2", 0, vo[0], 0);

    // full-rate streaming of 0..99, pipe and spill
    do_reset();
    for (int k = 0; k < 2; k++) begin
      s0[k] = sent[k]; q0[k] = rcv[k];
    end
    for (int c = 0; c < 102; c++) begin
      for (int k = 0; k < 2; k++) begin
        vi[k] = (sent[k] - s0[k]) < 100;
        di[k] = 8'(sent[k] - s0[k]);
        ri[k] = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++)
        if (vi[k]) chk("t2_rdy", k, ro[k], 1);
      step();
    end
    for (int k = 0; k < 2; k++)
      chk("t2_beats", k, rcv[k] - q0[k], 100);

    // spill backpressure: 4 accepted, ready drops
    do_reset();
    tx = 0;
    for (int c = 0; c < 4; c++) begin
      vi[1] = 1'b1; di[1] = 8'(tx); ri[1] = 1'b0;
      step();
      if (fired[1]) tx++;
    end
    di[1] = 8'(tx);
    #1;
    chk("t3_rdy", 1, ro[1], 0);
    chk("t3_cnt", 1, co[1], 4);
    chk("t3_acc", 1, tx, 4);
    ri[1] = 1'b1;
    r0 = rcv[1];
    for (int c = 0; c < 20 && rcv[1] - r0 < 5; c++) begin
      step();
      if (fired[1]) vi[1] = 1'b0;
    end
    chk("t3_out", 1, rcv[1] - r0, 5);

    // clear with a full chain
    do_reset();
    tx = 0;
    for (int c = 0; c < 6; c++) begin
      vi[1] = 1'b1; di[1] = 8'(tx); ri[1] = 1'b0;
      step();
      if (fired[1]) tx++;
    end
    #1;
    chk("t5_full", 1, co[1], 4);
    chk("t5_rdy", 1, ro[1], 0);
    clr = 1'b1; ri[1] = 1'b1;
    step();
    clr = 1'b0; vi[1] = 1'b0;
    #1;
    chk("t5_cnt", 1, co[1], 0);
    chk("t5_vld", 1, vo[1], 0);
    vi[1] = 1'b1; di[1] = 8'h3C;
    r0 = rcv[1];
    for (int c = 0; c < 10 && rcv[1] - r0 < 1; c++) begin
      step();
      if (fired[1]) vi[1] = 1'b0;
    end
    chk("t5_deliv", 1, rcv[1] - r0, 1);
    chk("t5_data", 1, last[1], 8'h3C);

    // asynchronous reset with beats in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      vi[1] = 1'b1; di[1] = 8'(8'h50 + c); ri[1] = 1'b0;
      step();
    end
    vi[1] = 1'b0;
    #1;
    chk("t6_cnt3", 1, co[1], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", 1, vo[1], 0);
    chk("t6_cnt", 1, co[1], 0);
    chk("t6_rdy", 1, ro[1], 1);
    do_reset();
    ri[1] = 1'b1;
    r0 = rcv[1];
    repeat (6) step();
    chk("t6_stale", 1, rcv[1] - r0, 0);

    // random valid/ready across all configs
    do_reset();
    for (int k = 0; k < NI; k++) rb[k] = rcv[k];
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < 60000) begin
      for (int k = 0; k < NI; k++) begin
        if (!(vi[k] && !fired[k])) begin
          vi[k] = 1'($urandom_range(0, 1));
          di[k] = 8'($urandom);
        end
        ri[k] = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
      busy = 1'b0;
      for (int k = 0; k < NI; k++)
        if (rcv[k] - rb[k] < 10000) busy = 1'b1;
    end
    for (int k = 0; k < NI; k++)
      chk("t4_beats", k, (rcv[k] - rb[k]) >= 10000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
